// File: rtl/uart_transceiver.sv
// Full-duplex UART: configurable width, divisor, parity and stop bits.
// Ports: clk/rst, tx_data_ready/tx_data -> tx, tx_busy, tx_data_sent;
// rx -> rx_data, rx_data_ready, rx_parity_err, rx_frame_err.
module uart_transceiver #(
  parameter int BITS         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_data_ready,
  input  logic [BITS-1:0] tx_data,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_data_sent,
  input  logic            rx,
  output logic [BITS-1:0] rx_data,
  output logic            rx_data_ready,
  output logic            rx_parity_err,
  output logic            rx_frame_err
);

  localparam int CW = $clog2(STOP_BITS*CLKS_PER_BIT+1);
  localparam int IW = $clog2(BITS+1);
  localparam logic [CW-1:0] BIT_END   = CW'(CLKS_PER_BIT-1);
  localparam logic [CW-1:0] HALF_END  = CW'(CLKS_PER_BIT/2-1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS*CLKS_PER_BIT-1);
  localparam logic [CW-1:0] STOP_PRE  = CW'(STOP_BITS*CLKS_PER_BIT-2);
  localparam logic [IW-1:0] LAST_BIT  = IW'(BITS-1);
  localparam logic ODD     = (PARITY == 1);
  localparam logic HAS_PAR = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t          tx_st;
  logic [CW-1:0]   tx_cnt;
  logic [IW-1:0]   tx_idx;
  logic [BITS-1:0] tx_sh;
  logic            tx_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st        <= S_IDLE;
      tx_cnt       <= '0;
      tx_idx       <= '0;
      tx_sh        <= '0;
      tx_par       <= 1'b0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_data_sent <= 1'b0;
    end else begin
      tx_data_sent <= 1'b0;
      unique case (tx_st)
        S_IDLE: begin
          if (tx_data_ready) begin
            tx_st   <= S_START;
            tx_sh   <= tx_data;
            // odd parity bit is the inverse of the data XOR
            tx_par  <= ODD ^ (^tx_data);
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            tx_cnt  <= '0;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            tx     <= tx_sh[0];
            tx_st  <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_idx == LAST_BIT) begin
              tx    <= HAS_PAR ? tx_par : 1'b1;
              tx_st <= HAS_PAR ? S_PAR : S_STOP;
            end else begin
              tx_idx <= tx_idx + IW'(1);
              tx_sh  <= tx_sh >> 1;
              tx     <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_PAR: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            tx     <= 1'b1;
            tx_st  <= S_STOP;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          // registered pulse lands on the final stop cycle
          if (tx_cnt == STOP_PRE)
            tx_data_sent <= 1'b1;
          if (tx_cnt == STOP_LAST) begin
            tx_cnt  <= '0;
            tx_busy <= 1'b0;
            tx_st   <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  logic            rx_s1;
  logic            rxs;
  state_t          rx_st;
  logic [CW-1:0]   rx_cnt;
  logic [IW-1:0]   rx_idx;
  logic [BITS-1:0] rx_sh;
  logic            rx_pbit;
  logic            wait_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1         <= 1'b1;
      rxs           <= 1'b1;
      rx_st         <= S_IDLE;
      rx_cnt        <= '0;
      rx_idx        <= '0;
      rx_sh         <= '0;
      rx_pbit       <= 1'b0;
      wait_high     <= 1'b0;
      rx_data       <= '0;
      rx_data_ready <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_s1         <= rx;
      rxs           <= rx_s1;
      rx_data_ready <= 1'b0;
      unique case (rx_st)
        S_IDLE: begin
          // after a break, a line held low must not retrigger
          if (wait_high) begin
            if (rxs)
              wait_high <= 1'b0;
          end else if (!rxs) begin
            rx_st  <= S_START;
            rx_cnt <= '0;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_st  <= rxs ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            rx_sh  <= {rxs, rx_sh[BITS-1:1]};
            if (rx_idx == LAST_BIT)
              rx_st <= HAS_PAR ? S_PAR : S_STOP;
            else
              rx_idx <= rx_idx + IW'(1);
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_PAR: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt  <= '0;
            rx_pbit <= rxs;
            rx_st   <= S_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt        <= '0;
            rx_st         <= S_IDLE;
            rx_data       <= rx_sh;
            rx_data_ready <= 1'b1;
            rx_parity_err <= HAS_PAR &
                             (rx_pbit ^ ODD ^ (^rx_sh));
            rx_frame_err  <= ~rxs;
            wait_high     <= ~rxs;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: 8E1 instance (loopback or driven rx)
// and 8O2 loopback instance, checked against a frame-level model.
module tb_uart_transceiver;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_req, a_tx, a_busy, a_sent, a_rx;
  logic       a_rdy, a_pe, a_fe, a_loop, drv_rx;
  logic [7:0] a_data, a_rdata;
  logic       b_req, b_tx, b_busy, b_sent, b_rx;
  logic       b_rdy, b_pe, b_fe;
  logic [7:0] b_data, b_rdata;

  assign a_rx = a_loop ? a_tx : drv_rx;
  assign b_rx = b_tx;

  uart_transceiver #(
    .BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .tx_data_ready(a_req), .tx_data(a_data),
    .tx(a_tx), .tx_busy(a_busy), .tx_data_sent(a_sent),
    .rx(a_rx), .rx_data(a_rdata), .rx_data_ready(a_rdy),
    .rx_parity_err(a_pe), .rx_frame_err(a_fe)
  );

  uart_transceiver #(
    .BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .tx_data_ready(b_req), .tx_data(b_data),
    .tx(b_tx), .tx_busy(b_busy), .tx_data_sent(b_sent),
    .rx(b_rx), .rx_data(b_rdata), .rx_data_ready(b_rdy),
    .rx_parity_err(b_pe), .rx_frame_err(b_fe)
  );

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_ev_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  rx_ev_t qa_drv[$];
  rx_ev_t qa_loop[$];
  rx_ev_t qb_loop[$];
  int ra_drv = 0;

  int ta = -1;
  int tb = -1;
  logic [7:0] da, db;
  logic xa_rdy, xb_rdy;
  logic [7:0] ea_d, eb_d;
  logic ea_pe, ea_fe, eb_pe, eb_fe;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic int flen(input int par, input int stop);
    return (1 + 8 + (par != 0 ? 1 : 0) + stop) * CPB;
  endfunction

  // rx falling in cycle T -> rx_data_ready in cycle T + rx_lat
  function automatic int rx_lat(input int par);
    return 2 + CPB/2 + (1 + 8 + (par != 0 ? 1 : 0)) * CPB + 1;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d,
                                     input int par,
                                     input int j);
    int b;
    b = j / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (par != 0 && b == 9)
      return (par == 1) ? ~(^d) : (^d);
    return 1'b1;
  endfunction

  task automatic model_loop();
    rx_ev_t ev;
    forever begin
      @(posedge clk);
      if (rst) begin
        ta = -1;
        tb = -1;
        ra_drv = qa_drv.size();
        qa_loop.delete();
        qb_loop.delete();
        ea_d = 8'h00; ea_pe = 1'b0; ea_fe = 1'b0;
        eb_d = 8'h00; eb_pe = 1'b0; eb_fe = 1'b0;
      end else begin
        if (ta >= 0) begin
          ta++;
          if (ta == flen(2, 1)) ta = -1;
        end else if (a_req) begin
          ta = 0;
          da = a_data;
          if (a_loop) begin
            ev.cyc = cyc + 1 + rx_lat(2);
            ev.d = a_data; ev.pe = 1'b0; ev.fe = 1'b0;
            qa_loop.push_back(ev);
          end
        end
        if (tb >= 0) begin
          tb++;
          if (tb == flen(1, 2)) tb = -1;
        end else if (b_req) begin
          tb = 0;
          db = b_data;
          ev.cyc = cyc + 1 + rx_lat(1);
          ev.d = b_data; ev.pe = 1'b0; ev.fe = 1'b0;
          qb_loop.push_back(ev);
        end
      end
      cyc++;
      xa_rdy = 1'b0;
      xb_rdy = 1'b0;
      if (qa_loop.size() > 0 && qa_loop[0].cyc == cyc) begin
        xa_rdy = 1'b1;
        ea_d = qa_loop[0].d; ea_pe = qa_loop[0].pe;
        ea_fe = qa_loop[0].fe;
        void'(qa_loop.pop_front());
      end
      if (ra_drv < qa_drv.size() && qa_drv[ra_drv].cyc == cyc) begin
        xa_rdy = 1'b1;
        ea_d = qa_drv[ra_drv].d; ea_pe = qa_drv[ra_drv].pe;
        ea_fe = qa_drv[ra_drv].fe;
        ra_drv++;
      end
      if (qb_loop.size() > 0 && qb_loop[0].cyc == cyc) begin
        xb_rdy = 1'b1;
        eb_d = qb_loop[0].d; eb_pe = qb_loop[0].pe;
        eb_fe = qb_loop[0].fe;
        void'(qb_loop.pop_front());
      end
    end
  endtask

  task automatic checker_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("a_tx", a_tx, (ta < 0) ? 1'b1 : frame_bit(da, 2, ta));
        check("a_busy", a_busy, ta >= 0);
        check("a_sent", a_sent, ta == flen(2, 1) - 1);
        check("a_rdy", a_rdy, xa_rdy);
        check("a_rdata", a_rdata, ea_d);
        check("a_pe", a_pe, ea_pe);
        check("a_fe", a_fe, ea_fe);
        check("b_tx", b_tx, (tb < 0) ? 1'b1 : frame_bit(db, 1, tb));
        check("b_busy", b_busy, tb >= 0);
        check("b_sent", b_sent, tb == flen(1, 2) - 1);
        check("b_rdy", b_rdy, xb_rdy);
        check("b_rdata", b_rdata, eb_d);
        check("b_pe", b_pe, eb_pe);
        check("b_fe", b_fe, eb_fe);
      end
    end
  endtask

  // drives one 8E1 frame on rx of instance a, then extra low bits
  task automatic send_frame(input logic [7:0] d, input logic pbit,
                            input logic stop, input int low_bits);
    rx_ev_t ev;
    @(negedge clk);
    drv_rx = 1'b0;
    ev.cyc = cyc + rx_lat(2);
    ev.d = d;
    ev.pe = pbit ^ (^d);
    ev.fe = ~stop;
    qa_drv.push_back(ev);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drv_rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    drv_rx = pbit;
    repeat (CPB) @(negedge clk);
    drv_rx = stop;
    repeat (CPB * (1 + low_bits)) @(negedge clk);
    drv_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  initial begin
    int ks, kr, nb, nr, ns;
    rst = 1'b1;
    a_req = 1'b0; a_data = 8'h00; a_loop = 1'b1; drv_rx = 1'b1;
    b_req = 1'b0; b_data = 8'h00;
    fork
      model_loop();
      checker_loop();
    join_none
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_tx", a_tx, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_sent", a_sent, 1'b0);
    check("rst_rdata", a_rdata, 8'h00);
    check("rst_rdy", a_rdy, 1'b0);
    check("rst_err", {a_pe, a_fe}, 2'b00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8E1 loopback of 0x55
    a_data = 8'h55; a_req = 1'b1;
    ks = 0; kr = 0; nb = 0;
    for (int k = 1; k <= 220; k++) begin
      @(negedge clk);
      if (k == 1) a_req = 1'b0;
      if (a_busy) nb++;
      if (k == 9) check("t1_start", a_tx, 1'b0);
      if (k == 25) check("t1_bit0", a_tx, 1'b1);
      if (k == 153) check("t1_parity", a_tx, 1'b0);
      if (a_rdy && kr == 0) begin
        kr = k;
        check("t1_rdata", a_rdata, 8'h55);
        check("t1_errs", {a_pe, a_fe}, 2'b00);
      end
      if (a_sent && ks == 0) ks = k;
    end
    check("t1_sent_cycle", ks, 176);
    check("t1_busy_len", nb, 176);
    check("t1_rdy_cycle", kr, 172);

    // 8O2 loopback, request held for back-to-back frames
    b_data = 8'h01; b_req = 1'b1;
    ks = 0; nr = 0;
    for (int k = 1; k <= 420; k++) begin
      @(negedge clk);
      if (k == 1) b_data = 8'h02;
      if (k == 153) check("t2_parity", b_tx, 1'b0);
      if (k == 193) begin
        check("t2_gap_tx", b_tx, 1'b1);
        check("t2_gap_busy", b_busy, 1'b0);
      end
      if (k == 194) begin
        check("t2_restart_tx", b_tx, 1'b0);
        check("t2_restart_busy", b_busy, 1'b1);
        b_req = 1'b0;
      end
      if (b_sent && ks == 0) ks = k;
      if (b_rdy) begin
        nr++;
        if (nr == 1) begin
          check("t2_rdy1_cycle", k, 172);
          check("t2_rdata1", b_rdata, 8'h01);
        end else begin
          check("t2_rdy2_cycle", k, 365);
          check("t2_rdata2", b_rdata, 8'h02);
        end
        check("t2_errs", {b_pe, b_fe}, 2'b00);
      end
    end
    check("t2_sent_cycle", ks, 192);
    check("t2_rdy_count", nr, 2);

    // bench-driven rx: parity error, then clean frame
    a_loop = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1, 0);
    check("t3_rdata", a_rdata, 8'h01);
    check("t3_perr", a_pe, 1'b1);
    send_frame(8'h80, 1'b1, 1'b1, 0);
    check("t3_rdata2", a_rdata, 8'h80);
    check("t3_perr_clr", a_pe, 1'b0);

    // break: stop low then 40 bit times low
    send_frame(8'h00, 1'b0, 1'b0, 40);
    check("t4_ferr", a_fe, 1'b1);
    check("t4_rdata", a_rdata, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    check("t4_ferr_clr", a_fe, 1'b0);
    check("t4_rdata2", a_rdata, 8'h3C);

    // 3-cycle glitch, then a valid frame
    @(negedge clk);
    drv_rx = 1'b0;
    repeat (3) @(negedge clk);
    drv_rx = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check("t5_rdata", a_rdata, 8'hA5);
    check("t5_errs", {a_pe, a_fe}, 2'b00);

    // request during busy is ignored
    a_loop = 1'b1;
    @(negedge clk);
    a_data = 8'h3C; a_req = 1'b1;
    for (int k = 1; k <= 220; k++) begin
      @(negedge clk);
      if (k == 1) a_req = 1'b0;
      if (k == 50) begin a_req = 1'b1; a_data = 8'hFF; end
      if (k == 51) a_req = 1'b0;
    end
    check("t6_rdata", a_rdata, 8'h3C);

    // reset mid-frame
    a_data = 8'h96; a_req = 1'b1;
    ns = 0; nr = 0;
    for (int k = 1; k <= 250; k++) begin
      @(negedge clk);
      if (k == 1) a_req = 1'b0;
      if (k == 60) rst = 1'b1;
      if (k == 61) begin
        rst = 1'b0;
        check("t7_tx", a_tx, 1'b1);
        check("t7_busy", a_busy, 1'b0);
        check("t7_rdata", a_rdata, 8'h00);
      end
      if (a_sent) ns++;
      if (a_rdy) nr++;
    end
    check("t7_no_sent", ns, 0);
    check("t7_no_rdy", nr, 0);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
